request_arb_unit: RTL
=====================

REQUEST_ARB_UNIT -- requirements
Module: request_arb_unit

Interface
REQ-001 Parameter NCH, default 2: number of requesting channels, legal range 2..8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter TO_W, default 8: timeout counter width.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset; synchronous and active-high.
REQ-006 req_ren  input  NCH  per-channel read request, level, held until done.
REQ-007 req_wen  input  NCH  per-channel write request, level, held until done.
REQ-008 req_addr  input  NCH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 mem_hit  input  1  memory completion for the current access.
REQ-010 mem_ren  output  1  memory read enable.
REQ-011 mem_wen  output  1  memory write enable.
REQ-012 mem_addr  output  ADDR_W  memory address of the current access.
REQ-013 grant  output  NCH  one-hot granted channel, all-zero when idle.
REQ-014 done  output  NCH  one-cycle completion pulse per channel.
REQ-015 busy  output  1  high while in state BUSY.
REQ-016 timeout_err  output  1  sticky timeout flag.

Function
REQ-017 The FSM SHALL have two states: IDLE and BUSY.
REQ-018 In IDLE with any req_ren|req_wen bit high, the unit SHALL select one channel round-robin, starting at rr_ptr and searching upward modulo NCH.
REQ-019 On selection, the unit SHALL register the granted channel, its address and its operation, then enter BUSY on the next edge; no memory enable is driven in IDLE.
REQ-020 If a channel asserts both req_wen and req_ren, the unit SHALL latch a write (mem_wen=1, mem_ren=0).
REQ-021 In BUSY, mem_ren/mem_wen/mem_addr/grant SHALL be driven from the latched values and held constant until completion; requester input changes SHALL be ignored.
REQ-022 In BUSY with mem_hit=1, the unit SHALL pulse done[granted] for exactly that cycle (combinational on mem_hit), set rr_ptr to (granted+1) mod NCH, and return to IDLE.
REQ-023 Minimum latency SHALL be: request at cycle 0, mem enable at cycle 1, done in the same cycle as mem_hit.
REQ-024 A channel still requesting in the cycle after its done SHALL be treated as a new request.
REQ-025 Between consecutive accesses, the unit SHALL spend exactly one cycle in IDLE with all memory enables low.
REQ-026 mem_hit in IDLE SHALL be ignored.
REQ-027 Fairness: with all channels requesting continuously, grants SHALL rotate 0,1,...,NCH-1,0.
REQ-028 busy SHALL equal (state==BUSY); grant SHALL be zero in IDLE.

Reset
REQ-029 With RST=1 at an edge: state=IDLE, rr_ptr=0, latched address/op cleared, timeout counter=0, and timeout_err=0.
REQ-030 After reset: mem_ren=0, mem_wen=0, mem_addr=0, grant=0, done=0, busy=0.
REQ-031 RST asserted during BUSY SHALL abort the access with no done pulse; a pending requester is re-arbitrated after reset.

Configuration
REQ-032 The macro REQUEST_ARB_UNIT_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-033 With the macro defined: a TO_W-bit counter clears on BUSY entry and increments each BUSY cycle without mem_hit; when it reaches 2^TO_W-1, the unit SHALL pulse done[granted], set timeout_err (sticky until RST), advance rr_ptr, and return to IDLE.
REQ-034 With the macro defined, mem_hit in the terminal-count cycle SHALL take precedence and timeout_err SHALL stay unchanged.
REQ-035 With the macro undefined: no counter, timeout_err tied 0, and BUSY waits indefinitely for mem_hit.

Verification
REQ-036 Single read: req_ren[1]=1, addr 0x40, mem_hit at cycle 3 -> mem_ren=1, mem_addr=0x40, grant=2'b10 in cycles 1-3; done[1] in cycle 3; IDLE in cycle 4.
REQ-037 Contention: NCH=2, both channels requesting continuously, mem_hit every BUSY cycle -> grant sequence 01,10,01,10; one IDLE cycle between grants.
REQ-038 Read+write on one channel: req_ren[0]=req_wen[0]=1 -> mem_wen=1, mem_ren=0.
REQ-039 Reset mid-access: RST in cycle 2 of BUSY -> all outputs 0 next cycle, no done pulse; a held request is re-granted from channel 0.
REQ-040 Timeout (macro on, TO_W=4): mem_hit never asserted -> done pulse after 15 BUSY cycles, timeout_err=1 and held; with mem_hit in cycle 15 instead, timeout_err stays 0.
REQ-041 Macro off: mem_hit withheld for 1000 cycles -> unit stays in BUSY, timeout_err=0.

Source files
------------

// File: rtl/request_arb_unit.sv
// request_arb_unit: round-robin arbiter that forwards one channel's read or
// write request to a single memory port and holds it until mem_hit.
// Optional watchdog: define REQUEST_ARB_UNIT_TIMEOUT_EN to abort an access
// whose mem_hit never arrives. It then reports the abort on the sticky
// timeout_err flag.
module request_arb_unit #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int TO_W   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NCH-1:0]        req_ren,
    input  logic [NCH-1:0]        req_wen,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    input  logic                  mem_hit,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [NCH-1:0]        grant,
    output logic [NCH-1:0]        done,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    gnt_idx;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;

    logic [ADDR_W-1:0]   ch_addr [NCH];
    logic                any_req;
    logic [PTR_W-1:0]    cand;
    logic                sel_found;
    logic [PTR_W-1:0]    sel_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_wr;

    logic [NCH-1:0]      gnt_oh;
    logic [PTR_W-1:0]    ptr_next;
    logic                to_fire;
    logic                fin;

    // Split the flat address bus into one word per channel.
    for (genvar g = 0; g < NCH; g++) begin : g_addr
        assign ch_addr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    assign any_req  = |(req_ren | req_wen);
    assign gnt_oh   = NCH'(1) << gnt_idx;
    assign ptr_next = (gnt_idx == PTR_W'(NCH - 1)) ? '0 : gnt_idx + PTR_W'(1);
    // An access ends on mem_hit, or on a watchdog expiry when that is built in.
    assign fin      = (state == BUSY) && (mem_hit || to_fire);

    // Round-robin search: first requester at or above rr_ptr, wrapping modulo NCH.
    always_comb begin
        cand      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_addr  = '0;
        sel_wr    = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NCH);
            if (!sel_found && (req_ren[cand] || req_wen[cand])) begin
                sel_found = 1'b1;
                sel_idx   = cand;
                sel_addr  = ch_addr[cand];
                // A write wins when a channel raises both request lines.
                sel_wr    = req_wen[cand];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE lasts exactly one cycle between accesses.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (fin)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: memory side is driven only from latched values while BUSY.
    always_comb begin
        busy     = 1'b0;
        grant    = '0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = '0;
        done     = '0;
        if (state == BUSY) begin
            busy     = 1'b1;
            grant    = gnt_oh;
            mem_ren  = !wr_q;
            mem_wen  = wr_q;
            mem_addr = addr_q;
            // A reset in the completing cycle aborts the access silently.
            if (fin && !RST) done = gnt_oh;
        end
    end

    // Latch the winner on IDLE->BUSY; advance the pointer past it on completion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr  <= '0;
            gnt_idx <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
        end else if (state == IDLE) begin
            if (sel_found) begin
                gnt_idx <= sel_idx;
                addr_q  <= sel_addr;
                wr_q    <= sel_wr;
            end
        end else if (fin) begin
            rr_ptr <= ptr_next;
        end
    end

`ifdef REQUEST_ARB_UNIT_TIMEOUT_EN
    // The counter reads N-1 in the Nth BUSY cycle, so expiry is one short of all-ones.
    localparam logic [TO_W-1:0] TC_M1 = {{(TO_W-1){1'b1}}, 1'b0};

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // mem_hit in the terminal cycle wins, so the watchdog only fires without it.
    assign to_fire     = (state == BUSY) && !mem_hit && (to_cnt == TC_M1);
    assign timeout_err = err_q;

    // Watchdog counter and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else if (!mem_hit) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_fire) err_q <= 1'b1;
        end
    end
`else
    logic [TO_W-1:0] unused_to_w;

    assign unused_to_w = '0;
    assign to_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
